// File: rtl/mul_add_if.sv
// Handshake bundle for the iterative multiply-accumulate unit: go/operands in,
// ready/error/result back. Same shape as the divider's bus.
interface mul_add_if #(
  parameter int WIDTH_LOG = 4
);
  localparam int WIDTH = 1 << WIDTH_LOG;

  logic             go;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             ready;
  logic             error;
  logic [WIDTH-1:0] result;

  modport master (
    output go, a, b, c,
    input  ready, error, result
  );

  modport slave (
    input  go, a, b, c,
    output ready, error, result
  );
endinterface

// File: rtl/mul_add.sv
// Iterative shift-add multiply-accumulate: result = a*b + c, error on carry past WIDTH bits.
// Build option MUL_ADD_SATURATE_EN: overflowed results saturate to all ones instead of wrapping.
module mul_add #(
  parameter int WIDTH_LOG = 4
) (
  input  logic      clk,
  input  logic      rst,
  mul_add_if.slave  bus
);
  localparam int WIDTH = 1 << WIDTH_LOG;
  localparam int HI    = WIDTH - 1;
  localparam int W2    = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_MUL   = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t           r_state, w_state_nx;
  logic             r_ready, r_error;
  logic [HI:0]      r_result, w_result_nx;
  logic [W2-1:0]    r_acc, w_acc_nx;
  logic [W2-1:0]    r_mreg, w_mreg_nx;
  logic [HI:0]      r_breg, w_breg_nx;
  logic             w_ovf;
  logic [HI:0]      w_result_fin;

  // Double-width accumulator cannot carry out: (2^W-1)^2 + 2^W-1 < 2^(2W).
  assign w_ovf = |r_acc[W2-1:WIDTH];

`ifdef MUL_ADD_SATURATE_EN
  assign w_result_fin = w_ovf ? {WIDTH{1'b1}} : r_acc[HI:0];
`else
  assign w_result_fin = r_acc[HI:0];
`endif

  always_comb begin
    w_state_nx  = r_state;
    w_acc_nx    = r_acc;
    w_mreg_nx   = r_mreg;
    w_breg_nx   = r_breg;
    w_result_nx = r_result;
    case (r_state)
      ST_READY, ST_ERROR: begin
        if (bus.go) begin
          w_state_nx = ST_MUL;
          w_acc_nx   = {{WIDTH{1'b0}}, bus.c};
          w_mreg_nx  = {{WIDTH{1'b0}}, bus.a};
          w_breg_nx  = bus.b;
        end
      end
      ST_MUL: begin
        if (r_breg != '0) begin
          if (r_breg[0]) w_acc_nx = r_acc + r_mreg;
          w_mreg_nx = r_mreg << 1;
          w_breg_nx = r_breg >> 1;
        end else begin
          w_result_nx = w_result_fin;
          w_state_nx  = w_ovf ? ST_ERROR : ST_READY;
        end
      end
      default: w_state_nx = state_t'(2'bxx);
    endcase
  end

  // Control and visible outputs; ready/error follow the next state so they are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_READY;
      r_ready  <= 1'b1;
      r_error  <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_ready  <= (w_state_nx == ST_READY) || (w_state_nx == ST_ERROR);
      r_error  <= (w_state_nx == ST_ERROR);
      r_result <= w_result_nx;
    end
  end

  // Datapath is only read in MUL after a load, so it needs no reset.
  always_ff @(posedge clk) begin
    r_acc  <= w_acc_nx;
    r_mreg <= w_mreg_nx;
    r_breg <= w_breg_nx;
  end

  assign bus.ready  = r_ready;
  assign bus.error  = r_error;
  assign bus.result = r_result;
endmodule

// File: tb/tb_mul_add.sv
// Directed bench for mul_add: scoreboard of expected result/error/latency, checked on ready.
module tb_mul_add;
  localparam int WIDTH_LOG = 4;
  localparam int WIDTH     = 1 << WIDTH_LOG;
`ifdef MUL_ADD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             err;
    int               lat;
  } exp_t;

  logic clk, rst;
  mul_add_if #(.WIDTH_LOG(WIDTH_LOG)) bus ();
  mul_add #(.WIDTH_LOG(WIDTH_LOG)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cnt++;
  endtask

  // Drive go for one edge, push the model's expectation, scramble operands afterwards.
  task automatic start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c);
    exp_t    e;
    longint  full;
    int      k;
    full = longint'(a) * longint'(b) + longint'(c);
    k = 0;
    for (int i = 0; i < WIDTH; i++) if (b[i]) k = i + 1;
    e.err = (full >= (longint'(1) << WIDTH));
    e.res = (e.err && SAT) ? {WIDTH{1'b1}} : full[WIDTH-1:0];
    e.lat = k + 1;
    sb.push_back(e);
    bus.go = 1'b1; bus.a = a; bus.b = b; bus.c = c;
    step();
    bus.go = 1'b0;
    bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.c = WIDTH'($urandom);
    chk("accept_busy", 32'(bus.ready), 32'd0);
    cnt = 0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    while (!bus.ready && cnt < WIDTH + 8) step();
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s: scoreboard empty, got result 0x%0h expected an entry", tag, bus.result);
    end else begin
      e = sb.pop_front();
      if (!bus.ready) begin
        checks++; errors++;
        $error("FAIL %s_timeout: got ready=0 after %0d edges expected ready=1", tag, cnt);
      end else begin
        chk({tag, "_lat"}, 32'(cnt), 32'(e.lat));
        chk({tag, "_result"}, 32'(bus.result), 32'(e.res));
        chk({tag, "_error"}, 32'(bus.error), 32'(e.err));
      end
    end
  endtask

  initial begin
    rst = 1'b1; bus.go = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);

    start(16'd7, 16'd5, 16'd3);               wait_done("t1");
    start(16'hFFFF, 16'd0, 16'h1234);         wait_done("t2");

    // Idle with go low holds everything.
    step(); step(); step();
    chk("idle_ready", 32'(bus.ready), 32'd1);
    chk("idle_result", 32'(bus.result), 32'h1234);

    start(16'h0100, 16'h0100, 16'd0);         wait_done("t3");
    start(16'hFFFF, 16'd1, 16'd1);            wait_done("t4");
    start(16'd2, 16'd3, 16'd0);               wait_done("t4b");

    // go mid-operation is ignored; result holds its old value while busy.
    start(16'h00FF, 16'h00FF, 16'd0);
    step(); step();
    chk("busy_hold", 32'(bus.result), 32'd6);
    bus.go = 1'b1; bus.a = 16'd1; bus.b = 16'd1; bus.c = 16'd1;
    step();
    bus.go = 1'b0;
    wait_done("t5");

    // Reset aborts an operation in flight.
    start(16'h00FF, 16'h00FF, 16'd0);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb.pop_front());
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_error", 32'(bus.error), 32'd0);
    chk("abort_result", 32'(bus.result), 32'd0);
    start(16'd7, 16'd5, 16'd3);               wait_done("t5_op1");

    // Divider round trip: 1000 = 142*7 + 6.
    start(16'd142, 16'd7, 16'd6);             wait_done("t6");

    // Back-to-back random ops, each started the first cycle ready is high.
    for (int i = 0; i < 6; i++) begin
      start(WIDTH'($urandom), WIDTH'($urandom_range(0, 300)), WIDTH'($urandom));
      wait_done("rand");
    end
    start(16'hFFFF, 16'hFFFF, 16'hFFFF);      wait_done("max");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
